// File: rtl/edge_pulse_gen_pkg.sv
// Shared definitions for the multi-channel edge-to-pulse converter:
// per-channel edge-select encodings carried on the MODE bus.
package edge_pulse_pkg;

    localparam int MODE_W = 2;

    localparam logic [MODE_W-1:0] MODE_NONE = 2'b00;
    localparam logic [MODE_W-1:0] MODE_RISE = 2'b01;
    localparam logic [MODE_W-1:0] MODE_FALL = 2'b10;
    localparam logic [MODE_W-1:0] MODE_BOTH = 2'b11;

endpackage

// File: rtl/edge_pulse_gen_ch.sv
// One edge-to-pulse channel: synchroniser, optional debounce, edge detect, pulse counter, overrun flag.
// Debounce stage is built only when EDGE_PULSE_GEN_DEBOUNCE_EN is defined.
module edge_pulse_ch
    import edge_pulse_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter logic INI         = 1'b0,
    parameter int   PULSE_LEN   = 1,
    parameter int   DEB_CYC     = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_i,
    input  logic [MODE_W-1:0] mode_i,
    input  logic              clr_ovr_i,
    output logic              out_o,
    output logic              ovr_o
);

    if (PULSE_LEN < 1) begin : g_bad_pulse_len
        $error("edge_pulse_ch: PULSE_LEN must be at least 1");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
        $error("edge_pulse_ch: SYNC_STAGES must be at least 2");
    end
    if (DEB_CYC < 1) begin : g_bad_deb_cyc
        $error("edge_pulse_ch: DEB_CYC must be at least 1");
    end

    localparam int CNT_W = (PULSE_LEN < 1) ? 1 : $clog2(PULSE_LEN + 1);
    localparam logic [CNT_W-1:0] LOAD = CNT_W'(PULSE_LEN);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_lvl;
    logic                   lvl;
    logic                   lvl_d_q;
    logic                   rise;
    logic                   fall;
    logic                   hit;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   out_q;
    logic                   out_d;
    logic                   ovr_q;
    logic                   ovr_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= {SYNC_STAGES{INI}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_i};
        end
    end

    assign sync_lvl = sync_q[SYNC_STAGES-1];

`ifdef EDGE_PULSE_GEN_DEBOUNCE_EN
    localparam int DEB_W = (DEB_CYC < 1) ? 1 : $clog2(DEB_CYC + 1);

    logic [DEB_W-1:0] deb_q;
    logic             lvl_q;

    // The filtered level only follows the synchroniser after it has disagreed for DEB_CYC cycles in a row.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            deb_q <= '0;
            lvl_q <= INI;
        end else if (sync_lvl == lvl_q) begin
            deb_q <= '0;
        end else if (deb_q == DEB_W'(DEB_CYC - 1)) begin
            deb_q <= '0;
            lvl_q <= sync_lvl;
        end else begin
            deb_q <= deb_q + DEB_W'(1);
        end
    end

    assign lvl = lvl_q;
`else
    assign lvl = sync_lvl;
`endif

    assign rise = lvl & ~lvl_d_q;
    assign fall = ~lvl & lvl_d_q;

    always_comb begin
        case (mode_i)
            MODE_RISE: hit = rise;
            MODE_FALL: hit = fall;
            MODE_BOTH: hit = rise | fall;
            default:   hit = 1'b0;
        endcase

        cnt_d = cnt_q;
        if (hit) begin
            cnt_d = LOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end

        // out_q mirrors cnt_q != 0 but comes straight from its own flop.
        out_d = (cnt_d != '0);
        ovr_d = (hit & out_q) | (ovr_q & ~clr_ovr_i);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lvl_d_q <= INI;
            cnt_q   <= '0;
            out_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            lvl_d_q <= lvl;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            ovr_q   <= ovr_d;
        end
    end

    assign out_o = out_q;
    assign ovr_o = ovr_q;

endmodule

// File: rtl/edge_pulse_gen.sv
// Multi-channel edge-to-pulse converter: N_CH independent edge_pulse_ch instances on one clock.
// Define EDGE_PULSE_GEN_DEBOUNCE_EN to add a DEB_CYC-cycle debounce filter to every channel.
module edge_pulse_gen
    import edge_pulse_pkg::*;
#(
    parameter int              N_CH        = 4,
    parameter int              SYNC_STAGES = 2,
    parameter logic [N_CH-1:0] INI         = '0,
    parameter int              PULSE_LEN   = 1,
    parameter int              DEB_CYC     = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [N_CH-1:0]          IN,
    input  logic [MODE_W*N_CH-1:0]   MODE,
    input  logic                     CLR_OVR,
    output logic [N_CH-1:0]          OUT,
    output logic [N_CH-1:0]          OVR
);

    if (N_CH < 1) begin : g_bad_n_ch
        $error("edge_pulse_gen: N_CH must be at least 1");
    end

    // INI is a per-channel bit vector: bit i is the idle level of channel i.
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        edge_pulse_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .INI         (INI[i]),
            .PULSE_LEN   (PULSE_LEN),
            .DEB_CYC     (DEB_CYC)
        ) u_ch (
            .clk_i     (CLK),
            .rst_i     (RST),
            .in_i      (IN[i]),
            .mode_i    (MODE[MODE_W*i +: MODE_W]),
            .clr_ovr_i (CLR_OVR),
            .out_o     (OUT[i]),
            .ovr_o     (OVR[i])
        );
    end

endmodule

// File: tb/tb_edge_pulse_gen.sv
// Directed bench for edge_pulse_gen: three instances (PULSE_LEN 3, 1, 4) driven from one vector table
// plus hand-written reset sequences; debounce rows replace the plain-latency rows when the macro is set.
module tb_edge_pulse_gen;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [3:0] in_v   [3];
    logic [7:0] mode_v [3];
    logic       clr_v  [3];
    logic [3:0] out_v  [3];
    logic [3:0] ovr_v  [3];

    always #5 CLK = ~CLK;

    edge_pulse_gen #(.N_CH(4), .SYNC_STAGES(2), .INI(4'b0000), .PULSE_LEN(3), .DEB_CYC(4)) dut_a (
        .CLK(CLK), .RST(RST), .IN(in_v[0]), .MODE(mode_v[0]), .CLR_OVR(clr_v[0]),
        .OUT(out_v[0]), .OVR(ovr_v[0])
    );
    edge_pulse_gen #(.N_CH(4), .SYNC_STAGES(2), .INI(4'b0000), .PULSE_LEN(1), .DEB_CYC(4)) dut_b (
        .CLK(CLK), .RST(RST), .IN(in_v[1]), .MODE(mode_v[1]), .CLR_OVR(clr_v[1]),
        .OUT(out_v[1]), .OVR(ovr_v[1])
    );
    edge_pulse_gen #(.N_CH(4), .SYNC_STAGES(2), .INI(4'b0010), .PULSE_LEN(4), .DEB_CYC(4)) dut_c (
        .CLK(CLK), .RST(RST), .IN(in_v[2]), .MODE(mode_v[2]), .CLR_OVR(clr_v[2]),
        .OUT(out_v[2]), .OVR(ovr_v[2])
    );

    typedef struct {
        int         sel;
        logic [3:0] in;
        logic [7:0] mode;
        logic       clr;
        logic [3:0] eout;
        logic [3:0] eovr;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic add(input int sel, input logic [3:0] in, input logic [7:0] mode, input logic clr,
                       input logic [3:0] eout, input logic [3:0] eovr);
        vec_t v;
        v.sel  = sel;
        v.in   = in;
        v.mode = mode;
        v.clr  = clr;
        v.eout = eout;
        v.eovr = eovr;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b", nm, act, exp);
        end
    endtask

    initial begin
        logic got;

        for (int d = 0; d < 3; d++) begin
            in_v[d]   = 4'b0000;
            mode_v[d] = 8'h00;
            clr_v[d]  = 1'b0;
        end
        // dut_c ch1 idles high and its input is held high through reset release.
        in_v[2]   = 4'b0010;
        mode_v[2] = 8'h0C;

        // ---- vector table ----
        for (int i = 0; i < 6; i++) add(2, 4'b0010, 8'h0C, 1'b0, 4'b0000, 4'b0000);

`ifndef EDGE_PULSE_GEN_DEBOUNCE_EN
        // dut_a, rise on ch0, PULSE_LEN=3: OUT high after edges 3..5.
        add(0, 4'b0001, 8'h55, 1'b0, 4'b0000, 4'b0000);
        add(0, 4'b0001, 8'h55, 1'b0, 4'b0000, 4'b0000);
        add(0, 4'b0001, 8'h55, 1'b0, 4'b0001, 4'b0000);
        add(0, 4'b0001, 8'h55, 1'b0, 4'b0001, 4'b0000);
        add(0, 4'b0001, 8'h55, 1'b0, 4'b0001, 4'b0000);
        add(0, 4'b0001, 8'h55, 1'b0, 4'b0000, 4'b0000);
        add(0, 4'b0001, 8'h55, 1'b0, 4'b0000, 4'b0000);
        for (int i = 0; i < 4; i++) add(0, 4'b0000, 8'h55, 1'b0, 4'b0000, 4'b0000);
        // MODE 00 while rising, then switch to 01 on a steady level: nothing.
        for (int i = 0; i < 4; i++) add(0, 4'b0001, 8'h54, 1'b0, 4'b0000, 4'b0000);
        for (int i = 0; i < 3; i++) add(0, 4'b0001, 8'h55, 1'b0, 4'b0000, 4'b0000);
        for (int i = 0; i < 4; i++) add(0, 4'b0000, 8'h55, 1'b0, 4'b0000, 4'b0000);
        // Next true rising edge produces a pulse.
        add(0, 4'b0001, 8'h55, 1'b0, 4'b0000, 4'b0000);
        add(0, 4'b0001, 8'h55, 1'b0, 4'b0000, 4'b0000);
        add(0, 4'b0001, 8'h55, 1'b0, 4'b0001, 4'b0000);
        add(0, 4'b0001, 8'h55, 1'b0, 4'b0001, 4'b0000);
        add(0, 4'b0001, 8'h55, 1'b0, 4'b0001, 4'b0000);
        add(0, 4'b0001, 8'h55, 1'b0, 4'b0000, 4'b0000);

        // dut_b, PULSE_LEN=1: ch0 MODE 11, ch1 MODE 00, same 10-cycle high on both.
        for (int i = 1; i <= 10; i++)
            add(1, 4'b0011, 8'h03, 1'b0, (i == 3) ? 4'b0001 : 4'b0000, 4'b0000);
        for (int i = 11; i <= 15; i++)
            add(1, 4'b0000, 8'h03, 1'b0, (i == 13) ? 4'b0001 : 4'b0000, 4'b0000);

        // dut_c, PULSE_LEN=4: rise then fall two cycles later merges into a 6-cycle pulse and sets OVR.
        for (int r = 0; r < 2; r++) begin
            add(2, 4'b0011, 8'h0F, 1'b0, 4'b0000, 4'b0000);
            add(2, 4'b0011, 8'h0F, 1'b0, 4'b0000, 4'b0000);
            add(2, 4'b0010, 8'h0F, 1'b0, 4'b0001, 4'b0000);
            add(2, 4'b0010, 8'h0F, 1'b0, 4'b0001, 4'b0000);
            // Second pass clears in the same cycle the overrun sets: set wins.
            add(2, 4'b0010, 8'h0F, (r == 1), 4'b0001, 4'b0001);
            add(2, 4'b0010, 8'h0F, 1'b0, 4'b0001, 4'b0001);
            add(2, 4'b0010, 8'h0F, 1'b0, 4'b0001, 4'b0001);
            add(2, 4'b0010, 8'h0F, 1'b0, 4'b0001, 4'b0001);
            add(2, 4'b0010, 8'h0F, 1'b0, 4'b0000, 4'b0001);
            add(2, 4'b0010, 8'h0F, 1'b0, 4'b0000, 4'b0001);
            add(2, 4'b0010, 8'h0F, 1'b1, 4'b0000, 4'b0000);
            add(2, 4'b0010, 8'h0F, 1'b0, 4'b0000, 4'b0000);
        end
`else
        // dut_a with DEB_CYC=4: a 3-cycle glitch is dropped.
        for (int i = 0; i < 3; i++) add(0, 4'b0001, 8'h55, 1'b0, 4'b0000, 4'b0000);
        for (int i = 0; i < 6; i++) add(0, 4'b0000, 8'h55, 1'b0, 4'b0000, 4'b0000);
        // A 5-cycle high passes: OUT high after edges 7..9.
        for (int i = 1; i <= 12; i++)
            add(0, (i <= 5) ? 4'b0001 : 4'b0000, 8'h55, 1'b0,
                (i >= 7 && i <= 9) ? 4'b0001 : 4'b0000, 4'b0000);
`endif

        // ---- reset state ----
        repeat (3) @(posedge CLK);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst.out%0d", d), out_v[d], 4'b0000);
            chk($sformatf("rst.ovr%0d", d), ovr_v[d], 4'b0000);
        end
        @(negedge CLK);
        RST = 1'b0;

        // ---- apply table ----
        foreach (vecs[k]) begin
            @(negedge CLK);
            in_v[vecs[k].sel]   = vecs[k].in;
            mode_v[vecs[k].sel] = vecs[k].mode;
            clr_v[vecs[k].sel]  = vecs[k].clr;
            @(posedge CLK);
            #1;
            chk($sformatf("v%0d.dut%0d.out", k, vecs[k].sel), out_v[vecs[k].sel], vecs[k].eout);
            chk($sformatf("v%0d.dut%0d.ovr", k, vecs[k].sel), ovr_v[vecs[k].sel], vecs[k].eovr);
        end

        // ---- reset mid-pulse ----
        @(negedge CLK);
        in_v[0]   = 4'b0000;
        mode_v[0] = 8'h55;
        repeat (4) @(negedge CLK);
        in_v[0] = 4'b0001;
        got = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            @(posedge CLK);
            #1;
            if (out_v[0][0]) got = 1'b1;
        end
        chk("mid.pulse_seen", {3'b000, got}, 4'b0001);
        #2;
        RST = 1'b1;
        #1;
        chk("mid.out_async", out_v[0], 4'b0000);
        in_v[0] = 4'b0000;
        @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge CLK);
            #1;
            chk($sformatf("post_rst.out.c%0d", i), out_v[0], 4'b0000);
        end
        chk("post_rst.ovr_c", ovr_v[2], 4'b0000);
        chk("post_rst.out_c", out_v[2], 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
